// File: rtl/fb_reader.sv
// fb_reader: fetches one YCbCr 4:2:2 frame over AXI4 INCR bursts and streams it as 16-bit pixels.
// Latency: start -> AR valid after one WAIT cycle; an accepted beat shows at pix_valid_o next cycle.
// Backpressure: pix_ready_i low holds the head pixel; a burst is issued only once it fits the FIFO.

module fb_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     wr_vld_i,
    input  logic [W-1:0]             wr_dat_i,
    input  logic                     rd_pop_i,
    output logic [W-1:0]             rd_dat_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(wr_vld_i);
        rd_ptr_d = rd_ptr_q + AW'(rd_pop_i);
        count_d  = count_q + (AW+1)'(wr_vld_i) - (AW+1)'(rd_pop_i);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; emptiness is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        if (wr_vld_i) mem_q[wr_ptr_q] <= wr_dat_i;
    end

    assign rd_dat_o = mem_q[rd_ptr_q];
    assign empty_o  = (count_q == '0);
    assign count_o  = count_q;
endmodule

module fb_reader #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          PIXELS     = 640*480,
    parameter int          BURST_LEN  = 16,
    parameter int          FIFO_DEPTH = 64
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic        err_o,
    output logic [31:0] araddr_o,
    output logic [7:0]  arlen_o,
    output logic [2:0]  arsize_o,
    output logic [1:0]  arburst_o,
    output logic        arvalid_o,
    input  logic        arready_i,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp_i,
    input  logic        rlast_i,
    input  logic        rvalid_i,
    output logic        rready_o,
    output logic [15:0] pix_o,
    output logic        pix_valid_o,
    input  logic        pix_ready_i
);
    localparam int WORDS  = PIXELS / 2;
    localparam int BURSTS = WORDS / BURST_LEN;
    localparam int BIDX_W = (BURSTS > 1) ? $clog2(BURSTS) : 1;
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ADDR, S_DATA} state_t;

    state_t             state_q, state_d;
    logic [BIDX_W-1:0]  burst_idx_q, burst_idx_d;
    logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic               err_q, err_d;
    logic               hsel_q, hsel_d;

    logic               beat_fire, last_beat, last_burst, pix_fire;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [31:0]        fifo_head;

    assign beat_fire  = rvalid_i & rready_o;
    assign last_beat  = (beat_cnt_q == BEAT_W'(BURST_LEN - 1));
    assign last_burst = (burst_idx_q == BIDX_W'(BURSTS - 1));
    assign pix_fire   = pix_valid_o & pix_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            burst_idx_q <= '0;
            beat_cnt_q  <= '0;
            err_q       <= 1'b0;
            hsel_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_idx_q <= burst_idx_d;
            beat_cnt_q  <= beat_cnt_d;
            err_q       <= err_d;
            hsel_q      <= hsel_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        burst_idx_d = burst_idx_q;
        beat_cnt_d  = beat_cnt_q;
        case (state_q)
            S_IDLE: if (start_i) begin
                burst_idx_d = '0;
                state_d     = S_WAIT;
            end
            // Reserving a whole burst of space here keeps DATA from ever overflowing.
            S_WAIT: if (fifo_count <= CNT_W'(FIFO_DEPTH - BURST_LEN)) state_d = S_ADDR;
            S_ADDR: if (arready_i) state_d = S_DATA;
            S_DATA: if (rvalid_i) begin
                if (last_beat) begin
                    beat_cnt_d = '0;
                    if (last_burst) begin
                        state_d = S_IDLE;
                    end else begin
                        burst_idx_d = burst_idx_q + BIDX_W'(1);
                        state_d     = S_WAIT;
                    end
                end else begin
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        err_d  = err_q | (beat_fire & ((rresp_i != 2'b00) | (rlast_i != last_beat)));
        hsel_d = hsel_q ^ pix_fire;
    end

    always_comb begin
        arvalid_o    = (state_q == S_ADDR);
        rready_o     = (state_q == S_DATA);
        busy_o       = (state_q != S_IDLE);
        frame_done_o = (state_q == S_DATA) & rvalid_i & last_beat & last_burst;
    end

    assign araddr_o  = BASE_ADDR + 32'(burst_idx_q) * 32'(BURST_LEN * 4);
    assign arlen_o   = 8'(BURST_LEN - 1);
    assign arsize_o  = 3'b010;
    assign arburst_o = 2'b01;
    assign err_o     = err_q;

    fb_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .wr_vld_i (beat_fire),
        .wr_dat_i (rdata_i),
        .rd_pop_i (pix_fire & hsel_q),
        .rd_dat_o (fifo_head),
        .empty_o  (fifo_empty),
        .count_o  (fifo_count)
    );

    // Gate the head so an empty FIFO shows a clean zero instead of stale storage.
    assign pix_valid_o = ~fifo_empty;
    assign pix_o       = fifo_empty ? 16'h0 : (hsel_q ? fifo_head[31:16] : fifo_head[15:0]);
endmodule
